// File: rtl/tug_game_ctrl_if.sv
// Player key inputs and playfield/score outputs of the tug-of-war round controller.
// The master side drives the keys and the slave side is the controller itself.
interface tug_game_ctrl_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  logic                  key_l;
  logic                  key_r;
  logic [NUM_LIGHTS-1:0] leds;
  logic [SCORE_W-1:0]    score_l;
  logic [SCORE_W-1:0]    score_r;
  logic [1:0]            winner;
  logic                  round_start;

  modport master (
    output key_l, key_r,
    input  leds, score_l, score_r, winner, round_start
  );

  modport slave (
    input  key_l, key_r,
    output leds, score_l, score_r, winner, round_start
  );
endinterface

// File: rtl/tug_game_ctrl.sv
// Tug-of-war round and score controller: turns key levels into presses, moves the lit
// position, scores rounds, holds the playfield dark between rounds and freezes at match end.
module tug_game_ctrl #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3,
  parameter int HOLDOFF    = 4
) (
  input  logic           clk,
  input  logic           reset,
  tug_game_ctrl_if.slave ctrl_io
);
  localparam int POS_W = (NUM_LIGHTS > 2) ? $clog2(NUM_LIGHTS) : 1;
  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [POS_W-1:0]   POS_CENTRE = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_LEFT   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]   POS_RIGHT  = POS_W'(0);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e                state_q,       state_d;
  logic [POS_W-1:0]      pos_q,         pos_d;
  logic [SCORE_W-1:0]    score_l_q,     score_l_d;
  logic [SCORE_W-1:0]    score_r_q,     score_r_d;
  logic [1:0]            winner_q,      winner_d;
  logic [NUM_LIGHTS-1:0] leds_q,        leds_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;
  logic                  round_start_q, round_start_d;
  logic                  key_l_q,       key_r_q;
  logic                  press_l_s,     press_r_s;
  logic                  win_s;

  function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [POS_W-1:0] p);
    onehot = NUM_LIGHTS'(1) << p;
  endfunction

  // Key history is updated in every state so a key held across a state change never presses
  assign press_l_s = ctrl_io.key_l & ~key_l_q;
  assign press_r_s = ctrl_io.key_r & ~key_r_q;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_PLAY;
      pos_q         <= POS_CENTRE;
      score_l_q     <= '0;
      score_r_q     <= '0;
      winner_q      <= 2'b00;
      leds_q        <= onehot(POS_CENTRE);
      cnt_q         <= '0;
      round_start_q <= 1'b1;
      key_l_q       <= 1'b0;
      key_r_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      winner_q      <= winner_d;
      leds_q        <= leds_d;
      cnt_q         <= cnt_d;
      round_start_q <= round_start_d;
      key_l_q       <= ctrl_io.key_l;
      key_r_q       <= ctrl_io.key_r;
    end
  end

  // Next-state logic: movement, win detection, hold countdown and match end
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    winner_d      = winner_q;
    cnt_d         = cnt_q;
    round_start_d = 1'b0;
    win_s         = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (press_l_s && !press_r_s) begin
          if (pos_q == POS_LEFT) begin
            score_l_d = score_l_q + SCORE_W'(1);
            winner_d  = 2'b01;
            win_s     = 1'b1;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (press_r_s && !press_l_s) begin
          if (pos_q == POS_RIGHT) begin
            score_r_d = score_r_q + SCORE_W'(1);
            winner_d  = 2'b10;
            win_s     = 1'b1;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end else begin
          pos_d = pos_q;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d       = ST_PLAY;
          pos_d         = POS_CENTRE;
          winner_d      = 2'b00;
          round_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_OVER;
      end
    endcase

    // A point reaching the maximum ends the match before any score can wrap
    if (win_s) begin
      if ((score_l_d == SCORE_MAX) || (score_r_d == SCORE_MAX)) begin
        state_d = ST_OVER;
      end else begin
        state_d = ST_HOLD;
        cnt_d   = HOLD_LOAD;
      end
    end else begin
      state_d = state_d;
    end

    leds_d = (state_d == ST_PLAY) ? onehot(pos_d) : '0;
  end

  assign ctrl_io.leds        = leds_q;
  assign ctrl_io.score_l     = score_l_q;
  assign ctrl_io.score_r     = score_r_q;
  assign ctrl_io.winner      = winner_q;
  assign ctrl_io.round_start = round_start_q;
endmodule

// File: tb/tb_tug_game_ctrl.sv
// Self-checking bench for tug_game_ctrl: vector table, directed corner sequences and
// randomized keys compared against a rule-level reference model.
module tb_tug_game_ctrl;
  localparam int N    = 9;
  localparam int SW   = 3;
  localparam int HO   = 4;
  localparam int C    = (N - 1) / 2;
  localparam int MAXS = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset;

  tug_game_ctrl_if #(.NUM_LIGHTS(N), .SCORE_W(SW)) bus ();

  tug_game_ctrl #(.NUM_LIGHTS(N), .SCORE_W(SW), .HOLDOFF(HO)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_io (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: light offset, scores, remaining dark cycles, match-over flag
  int m_pos, m_sl, m_sr, m_win, m_dark, m_rs;
  bit m_over, m_pkl, m_pkr;

  task automatic model_step(input bit rst, input bit kl, input bit kr);
    bit pl, pr;
    if (rst) begin
      m_pos = C; m_sl = 0; m_sr = 0; m_win = 0; m_dark = 0; m_rs = 1;
      m_over = 1'b0; m_pkl = 1'b0; m_pkr = 1'b0;
    end else begin
      pl = kl && !m_pkl;
      pr = kr && !m_pkr;
      m_pkl = kl;
      m_pkr = kr;
      m_rs = 0;
      if (m_over) begin
        m_rs = 0;
      end else if (m_dark > 0) begin
        m_dark--;
        if (m_dark == 0) begin
          m_pos = C; m_win = 0; m_rs = 1;
        end
      end else if (pl && !pr) begin
        if (m_pos == N - 1) begin
          m_sl++; m_win = 1;
          if (m_sl == MAXS) m_over = 1'b1; else m_dark = HO;
        end else m_pos++;
      end else if (pr && !pl) begin
        if (m_pos == 0) begin
          m_sr++; m_win = 2;
          if (m_sr == MAXS) m_over = 1'b1; else m_dark = HO;
        end else m_pos--;
      end
    end
  endtask

  function automatic logic [N-1:0] m_leds();
    logic [N-1:0] v;
    v = '0;
    if (!m_over && m_dark == 0) v[m_pos] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input bit rst, input bit kl, input bit kr);
    reset     = rst;
    bus.key_l = kl;
    bus.key_r = kr;
    @(posedge clk);
    model_step(rst, kl, kr);
    #1;
    chk("model_leds",    32'(bus.leds),        32'(m_leds()));
    chk("model_score_l", 32'(bus.score_l),     32'(m_sl));
    chk("model_score_r", 32'(bus.score_r),     32'(m_sr));
    chk("model_winner",  32'(bus.winner),      32'(m_win));
    chk("model_rstart",  32'(bus.round_start), 32'(m_rs));
  endtask

  task automatic press_pair(input bit left);
    apply(1'b0, left, !left);
    apply(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit           rst, kl, kr;
    logic [N-1:0] leds;
    int           sl, sr;
    logic [1:0]   win;
    bit           rs;
  } vec_t;

  localparam int NV = 17;
  vec_t tv[NV];

  function automatic vec_t mk(bit rst, bit kl, bit kr, logic [N-1:0] leds, bit rs);
    vec_t v;
    v.rst = rst; v.kl = kl; v.kr = kr; v.leds = leds;
    v.sl = 0; v.sr = 0; v.win = 2'b00; v.rs = rs;
    return v;
  endfunction

  initial begin
    int guard, rs_cnt;
    reset = 1'b1; bus.key_l = 1'b0; bus.key_r = 1'b0;

    tv[0]  = mk(1, 0, 0, 9'b000010000, 1);
    tv[1]  = mk(1, 0, 0, 9'b000010000, 1);
    tv[2]  = mk(0, 0, 0, 9'b000010000, 0);
    tv[3]  = mk(0, 1, 0, 9'b000100000, 0);
    tv[4]  = mk(0, 1, 0, 9'b000100000, 0);
    tv[5]  = mk(0, 1, 0, 9'b000100000, 0);
    tv[6]  = mk(0, 1, 0, 9'b000100000, 0);
    tv[7]  = mk(0, 1, 0, 9'b000100000, 0);
    tv[8]  = mk(0, 0, 0, 9'b000100000, 0);
    tv[9]  = mk(0, 0, 1, 9'b000010000, 0);
    tv[10] = mk(0, 0, 0, 9'b000010000, 0);
    tv[11] = mk(0, 1, 1, 9'b000010000, 0);
    tv[12] = mk(0, 0, 0, 9'b000010000, 0);
    tv[13] = mk(0, 0, 1, 9'b000001000, 0);
    tv[14] = mk(0, 0, 0, 9'b000001000, 0);
    tv[15] = mk(0, 1, 0, 9'b000010000, 0);
    tv[16] = mk(0, 0, 0, 9'b000010000, 0);

    for (int i = 0; i < NV; i++) begin
      apply(tv[i].rst, tv[i].kl, tv[i].kr);
      chk("tv_leds",    32'(bus.leds),        32'(tv[i].leds));
      chk("tv_score_l", 32'(bus.score_l),     32'(tv[i].sl));
      chk("tv_score_r", 32'(bus.score_r),     32'(tv[i].sr));
      chk("tv_winner",  32'(bus.winner),      32'(tv[i].win));
      chk("tv_rstart",  32'(bus.round_start), 32'(tv[i].rs));
    end

    // Left walks off the left end, then the fixed dark period and restart
    for (int i = 0; i < 4; i++) press_pair(1'b1);
    chk("left_edge_leds", 32'(bus.leds), 32'h100);
    apply(1'b0, 1'b1, 1'b0);
    chk("lwin_leds",   32'(bus.leds),    32'h0);
    chk("lwin_score",  32'(bus.score_l), 32'd1);
    chk("lwin_winner", 32'(bus.winner),  32'h1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      chk("hold_dark", 32'(bus.leds), 32'h0);
    end
    apply(1'b0, 1'b0, 1'b0);
    chk("restart_leds",   32'(bus.leds),        32'h010);
    chk("restart_winner", 32'(bus.winner),      32'h0);
    chk("restart_pulse",  32'(bus.round_start), 32'h1);
    apply(1'b0, 1'b0, 1'b0);
    chk("restart_pulse_end", 32'(bus.round_start), 32'h0);

    // Right wins, key_r toggling through the hold must be ignored
    for (int i = 0; i < 4; i++) press_pair(1'b0);
    apply(1'b0, 1'b0, 1'b1);
    chk("rwin_winner", 32'(bus.winner), 32'h2);
    for (int i = 0; i < HO; i++) apply(1'b0, 1'b0, (i % 2) == 1);
    chk("hold_tog_leds", 32'(bus.leds),    32'h010);
    chk("hold_tog_sl",   32'(bus.score_l), 32'd1);
    chk("hold_tog_sr",   32'(bus.score_r), 32'd1);
    apply(1'b0, 1'b0, 1'b0);

    // Right wins the match; the playfield then stays frozen
    guard = 0;
    while (!m_over && guard < 400) begin
      if (m_dark == 0) press_pair(1'b0); else apply(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("over_reached", 32'(m_over), 32'd1);
    chk("over_sr",      32'(bus.score_r), 32'd7);
    chk("over_winner",  32'(bus.winner),  32'h2);
    chk("over_leds",    32'(bus.leds),    32'h0);
    for (int i = 0; i < 20; i++) apply(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("over_frozen_sr", 32'(bus.score_r), 32'd7);
    chk("over_frozen_sl", 32'(bus.score_l), 32'd1);
    apply(1'b1, 1'b0, 1'b0);
    chk("over_rst_sr",   32'(bus.score_r), 32'd0);
    chk("over_rst_leds", 32'(bus.leds),    32'h010);
    apply(1'b0, 1'b0, 1'b0);

    // Reset two cycles into a hold aborts it with no late round_start
    for (int i = 0; i < 5; i++) press_pair(1'b1);
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    chk("hrst_sl",     32'(bus.score_l), 32'd0);
    chk("hrst_sr",     32'(bus.score_r), 32'd0);
    chk("hrst_winner", 32'(bus.winner),  32'h0);
    chk("hrst_leds",   32'(bus.leds),    32'h010);
    rs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      rs_cnt += int'(bus.round_start);
    end
    chk("hrst_no_stale", 32'(rs_cnt), 32'd0);

    // Randomized keys with occasional reset
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
